mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequencer for data-memory accesses in the 64-bit multicycle RISC-V core; sits between the main control unit, the doubleword-wide data memory and the register writeback path.
- Handles loads (lb/lh/lw/ld/lbu/lhu/lwu): lane extraction, sign/zero extension, writeback strobe.
- Handles stores (sb/sh/sw/sd): sub-word stores run as read-modify-write.
- Detects misaligned/illegal requests and memory acknowledge timeouts.

Parameters:
- TIMEOUT, 255, max cycles a request waits for MEM_ACK before aborting with ERR.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- START  input  1  request pulse; sampled only in IDLE
- IS_STORE  input  1  1 = store, 0 = load
- FUNCT3  input  3  RISC-V funct3 of the memory instruction
- ADDR  input  64  byte address
- STORE_DATA  input  64  rs2 value for stores
- MEM_RDATA  input  64  memory read doubleword
- MEM_ACK  input  1  memory completes current RD/WR this cycle
- MEM_ADDR  output  64  {ADDR_q[63:3], 3'b000}
- MEM_WDATA  output  64  write doubleword
- MEM_RD  output  1  read request
- MEM_WR  output  1  write request
- LOAD_RESULT  output  64  extended load value, held until next load completes
- REG_WRITE  output  1  one-cycle writeback strobe for loads
- DONE  output  1  one-cycle completion pulse (loads and stores)
- BUSY  output  1  high in every state except IDLE
- MISALIGNED  output  1  one-cycle fault pulse, no memory access made
- ERR  output  1  one-cycle timeout pulse

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; all outputs 0, including LOAD_RESULT and MEM_ADDR; timeout counter 0. Reset mid-operation aborts immediately; no DONE, REG_WRITE or ERR is emitted for the aborted access.
- START in IDLE latches IS_STORE, FUNCT3, ADDR and STORE_DATA into _q registers. START outside IDLE is ignored.
- States: IDLE, RD_REQ, WR_REQ, FINISH, FAULT.
- Check order at START, evaluated in IDLE:
  - Illegal: store with FUNCT3>3, or load with FUNCT3=111. Go to FAULT.
  - Misaligned: half with ADDR[0]!=0, word with ADDR[1:0]!=0, dword with ADDR[2:0]!=0. Go to FAULT.
  - Otherwise: sd goes to WR_REQ; every other access goes to RD_REQ.
- FAULT: MISALIGNED=1 for one cycle (also used for illegal funct3), DONE=0, then IDLE.
- RD_REQ:
  - MEM_RD=1 until and including the MEM_ACK cycle.
  - On ACK, capture MEM_RDATA into RDATA_q.
  - Load: go to FINISH. Sub-word store: go to WR_REQ.
- WR_REQ:
  - MEM_WR=1 until and including the ACK cycle; then FINISH.
  - sd: MEM_WDATA=STORE_DATA_q.
  - sb/sh/sw: MEM_WDATA=RDATA_q with the lane at byte offset ADDR_q[2:0] replaced by the low 8/16/32 bits of STORE_DATA_q. All other bytes are unchanged.
- FINISH: DONE=1. For loads, REG_WRITE=1 and LOAD_RESULT is updated at the same edge DONE rises. Then IDLE.
- Load extraction: lane = RDATA_q >> (8*ADDR_q[2:0]).
  - lb/lh/lw: sign-extend from bit 7/15/31.
  - lbu/lhu/lwu: zero-extend.
  - ld: full 64 bits.
- Timeout:
  - Counter clears on entry to RD_REQ/WR_REQ and increments each cycle without ACK.
  - When the count reaches TIMEOUT with no ACK: ERR=1 for one cycle, request deasserted, go to IDLE, no DONE.
  - ACK in the same cycle the count reaches TIMEOUT wins: normal completion.
- MEM_RD and MEM_WR are never both high. Both are 0 in IDLE, FINISH and FAULT.
- MEM_ACK is ignored outside RD_REQ and WR_REQ.
- Latency, with ACK in the first request cycle and START at cycle 0:
  - load: DONE at cycle 2
  - sd: DONE at cycle 2
  - sb/sh/sw: DONE at cycle 3
  - fault: MISALIGNED at cycle 1

Test Plan:
- lb, ADDR=0x1003, MEM_RDATA=0x00000000_80FF0000, immediate ACK -> MEM_ADDR=0x1000, REG_WRITE+DONE at cycle 2, LOAD_RESULT=0xFFFFFFFF_FFFFFF80. Same access with lbu -> 0x80.
- lw, ADDR=0x2004, MEM_RDATA=0x7654_3210_xxxx_xxxx, ACK after 3 wait cycles -> MEM_RD high 4 cycles, LOAD_RESULT=0x00000000_76543210, DONE 1 cycle after ACK.
- sh, ADDR=0x3002, STORE_DATA=0xABCD, read returns 0x11223344_55667788 -> MEM_WR with MEM_WDATA=0x11223344_ABCD7788, DONE at cycle 3, REG_WRITE stays 0.
- sd at ADDR=0x4000 -> no MEM_RD, MEM_WDATA=STORE_DATA; lw at ADDR=0x4002 -> MISALIGNED pulse at cycle 1, MEM_RD/MEM_WR never asserted; store with FUNCT3=100 -> MISALIGNED.
- TIMEOUT=4, no ACK -> ERR pulse after 4 request cycles, BUSY falls, no DONE. Repeat with ACK on the 4th cycle -> normal DONE, no ERR.
- reset_n low during RD_REQ -> next cycle all outputs 0, state IDLE. START during BUSY -> ignored, latched ADDR unchanged.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Bundles the request, data-memory and writeback signals of
//               the data-memory access sequencer.
//               slave  - seen from the sequencer (mem_access_ctrl)
//               master - seen from the control unit / memory side
//               Request in : START, IS_STORE, FUNCT3, ADDR, STORE_DATA
//               Memory in  : MEM_RDATA, MEM_ACK
//               Memory out : MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR
//               Result out : LOAD_RESULT, REG_WRITE, DONE, BUSY,
//                            MISALIGNED, ERR
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
  // Request from the main control unit
  logic        START;
  logic        IS_STORE;
  logic [2:0]  FUNCT3;
  logic [63:0] ADDR;
  logic [63:0] STORE_DATA;
  // Data memory return path
  logic [63:0] MEM_RDATA;
  logic        MEM_ACK;
  // Data memory request path
  logic [63:0] MEM_ADDR;
  logic [63:0] MEM_WDATA;
  logic        MEM_RD;
  logic        MEM_WR;
  // Writeback and status
  logic [63:0] LOAD_RESULT;
  logic        REG_WRITE;
  logic        DONE;
  logic        BUSY;
  logic        MISALIGNED;
  logic        ERR;

  modport slave (
    input  START, IS_STORE, FUNCT3, ADDR, STORE_DATA, MEM_RDATA, MEM_ACK,
    output MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR,
    output LOAD_RESULT, REG_WRITE, DONE, BUSY, MISALIGNED, ERR
  );

  modport master (
    output START, IS_STORE, FUNCT3, ADDR, STORE_DATA, MEM_RDATA, MEM_ACK,
    input  MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR,
    input  LOAD_RESULT, REG_WRITE, DONE, BUSY, MISALIGNED, ERR
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Data-memory access sequencer for the 64-bit multicycle
//               RISC-V core. Runs loads (lb/lh/lw/ld/lbu/lhu/lwu) with lane
//               extraction and sign/zero extension, stores (sb/sh/sw/sd)
//               with read-modify-write for sub-doubleword sizes, and flags
//               illegal/misaligned requests and memory acknowledge timeouts.
// Ports       : clk     - core clock, rising edge
//               reset_n - synchronous active-low reset
//               bus     - mem_access_ctrl_if.slave (request, memory and
//                         writeback signals)
// Parameters  : TIMEOUT - request cycles without MEM_ACK before ERR (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_access_ctrl_if.slave bus
);

  // The counter only ever has to hold 0 .. TIMEOUT-1: the cycle that would
  // take it to TIMEOUT is the abort cycle itself.
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_WR_REQ = 3'd2,
    S_FINISH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Lane extraction for loads: shift the addressed lane down to bit 0, then
  // sign- or zero-extend according to funct3.
  // --------------------------------------------------------------------------
  function automatic logic [63:0] load_extend(
    input logic [63:0] dword,
    input logic [2:0]  offset,
    input logic [2:0]  funct3
  );
    logic [63:0] lane;
    lane = dword >> {offset, 3'b000};
    case (funct3)
      3'b000:  load_extend = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_extend = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_extend = {{32{lane[31]}}, lane[31:0]};
      3'b011:  load_extend = lane;
      3'b100:  load_extend = {56'd0, lane[7:0]};
      3'b101:  load_extend = {48'd0, lane[15:0]};
      3'b110:  load_extend = {32'd0, lane[31:0]};
      default: load_extend = '0;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Read-modify-write merge: replace the addressed lane of the doubleword
  // read from memory with the low bits of the store data.
  // --------------------------------------------------------------------------
  function automatic logic [63:0] store_merge(
    input logic [63:0] dword,
    input logic [63:0] wdata,
    input logic [2:0]  offset,
    input logic [1:0]  size
  );
    logic [63:0] mask;
    case (size)
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
    store_merge = (dword & ~(mask << {offset, 3'b000}))
                | ((wdata & mask) << {offset, 3'b000});
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [63:0]      addr_q;
  logic [63:0]      store_data_q;
  logic [63:0]      rdata_q;
  logic [63:0]      load_result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_rd_q;
  logic             mem_wr_q;
  logic             done_q;
  logic             reg_write_q;
  logic             misaligned_q;
  logic             err_q;

  // --------------------------------------------------------------------------
  // Request classification, evaluated on the live request inputs in IDLE.
  // Both illegal and misaligned requests end in FAULT, so their relative
  // priority has no visible effect.
  // --------------------------------------------------------------------------
  logic req_illegal;
  logic req_misaligned;
  logic req_is_sd;

  always_comb begin
    req_illegal    = bus.IS_STORE ? (bus.FUNCT3 > 3'd3) : (bus.FUNCT3 == 3'b111);
    req_misaligned = 1'b0;
    case (bus.FUNCT3[1:0])
      2'b01:   req_misaligned = bus.ADDR[0];
      2'b10:   req_misaligned = |bus.ADDR[1:0];
      2'b11:   req_misaligned = |bus.ADDR[2:0];
      default: req_misaligned = 1'b0;
    endcase
    // A full doubleword store needs no read phase.
    req_is_sd = bus.IS_STORE && (bus.FUNCT3 == 3'b011);
  end

  // --------------------------------------------------------------------------
  // Write data: only driven while the write request is outstanding.
  // --------------------------------------------------------------------------
  logic [63:0] store_wdata;

  always_comb begin
    if (funct3_q[1:0] == 2'b11) begin
      store_wdata = store_data_q;
    end else begin
      store_wdata = store_merge(rdata_q, store_data_q, addr_q[2:0], funct3_q[1:0]);
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= '0;
      addr_q        <= '0;
      store_data_q  <= '0;
      rdata_q       <= '0;
      load_result_q <= '0;
      cnt_q         <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      done_q        <= 1'b0;
      reg_write_q   <= 1'b0;
      misaligned_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless set below.
      done_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            is_store_q   <= bus.IS_STORE;
            funct3_q     <= bus.FUNCT3;
            addr_q       <= bus.ADDR;
            store_data_q <= bus.STORE_DATA;
            cnt_q        <= '0;
            if (req_illegal || req_misaligned) begin
              state_q      <= S_FAULT;
              misaligned_q <= 1'b1;
            end else if (req_is_sd) begin
              state_q  <= S_WR_REQ;
              mem_wr_q <= 1'b1;
            end else begin
              state_q  <= S_RD_REQ;
              mem_rd_q <= 1'b1;
            end
          end
        end

        S_RD_REQ: begin
          if (bus.MEM_ACK) begin
            rdata_q  <= bus.MEM_RDATA;
            mem_rd_q <= 1'b0;
            if (is_store_q) begin
              state_q  <= S_WR_REQ;
              mem_wr_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              // Extract straight from the returned doubleword so the result
              // is valid in the same cycle DONE/REG_WRITE are seen.
              state_q       <= S_FINISH;
              done_q        <= 1'b1;
              reg_write_q   <= 1'b1;
              load_result_q <= load_extend(bus.MEM_RDATA, addr_q[2:0], funct3_q);
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= S_IDLE;
            mem_rd_q <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WR_REQ: begin
          if (bus.MEM_ACK) begin
            state_q  <= S_FINISH;
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= S_IDLE;
            mem_wr_q <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
        end

        S_FAULT: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q  <= S_IDLE;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.MEM_ADDR    = {addr_q[63:3], 3'b000};
  assign bus.MEM_WDATA   = (state_q == S_WR_REQ) ? store_wdata : '0;
  assign bus.MEM_RD      = mem_rd_q;
  assign bus.MEM_WR      = mem_wr_q;
  assign bus.LOAD_RESULT = load_result_q;
  assign bus.REG_WRITE   = reg_write_q;
  assign bus.DONE        = done_q;
  assign bus.BUSY        = (state_q != S_IDLE);
  assign bus.MISALIGNED  = misaligned_q;
  assign bus.ERR         = err_q;

endmodule
`default_nettype wire
